// File: rtl/cpu_pkg.sv
// Shared defaults and index types for the register-write path.
package cpu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_NREG  = 8;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_NREG  = 16;

    // Sized for the largest legal configuration so one type fits every instance.
    typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;
    typedef logic [$clog2(MAX_NREG)-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    int unsigned ptr_u;
    int unsigned best;
    int unsigned off;

    // Each requester's distance from the pointer; the nearest set one wins.
    always_comb begin
        grant = '0;
        ptr_u = 32'(ptr);
        best  = N;
        off   = 0;
        for (int unsigned j = 0; j < N; j++) begin
            off = (j + N - ptr_u) % N;
            if (req[j] && (off < best)) best = off;
        end
        for (int unsigned j = 0; j < N; j++) begin
            off      = (j + N - ptr_u) % N;
            grant[j] = req[j] && (off == best);
        end
    end

    assign valid = |grant;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one register-bank write per cycle, with a
// loadable write-protect mask that rejects writes to protected registers.
module reg_write_arbiter
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int NREG  = DEF_NREG
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*$clog2(NREG)-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0]           req_data,
    input  logic                            cfg_we,
    input  logic [NREG-1:0]                 cfg_wp,
    output logic [NREQ-1:0]                 ack,
    output logic                            err,
    output logic [NREG-1:0]                 wr_en,
    output logic [WIDTH-1:0]                wr_data,
    output logic [NREG-1:0]                 wp_mask
);

    localparam int AW = $clog2(NREG);

    req_idx_t          rr_ptr;
    req_idx_t          g_idx;
    req_idx_t          next_ptr;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic              grant_valid;
    logic [AW-1:0]     g_addr;
    logic [WIDTH-1:0]  g_data;
    logic              in_range;
    logic              reject;

    // A requester being acked this cycle still holds req; keep it out.
    assign elig = req & ~ack;

    rr_arbiter #(
        .N  (NREQ),
        .PW ($bits(req_idx_t))
    ) u_rr (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        g_idx  = '0;
        g_addr = '0;
        g_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_idx  = req_idx_t'(i);
                g_addr = req_addr[i*AW +: AW];
                g_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_range = 32'(g_addr) < NREG;
    assign reject   = !in_range || wp_mask[g_addr];
    assign next_ptr = (32'(g_idx) == NREQ - 1) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= '0;
            err     <= 1'b0;
            wr_en   <= '0;
            wr_data <= '0;
            wp_mask <= '0;
            rr_ptr  <= '0;
        end else begin
            // Arbitration below sees the pre-load mask.
            if (cfg_we) wp_mask <= cfg_wp;
            ack   <= grant;
            err   <= grant_valid && reject;
            wr_en <= (grant_valid && !reject) ? (NREG'(1) << g_addr) : '0;
            if (grant_valid && !reject) wr_data <= g_data;
            if (grant_valid) rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each grant, a monitor checks outputs.
module tb_reg_write_arbiter;
    import cpu_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int AW    = 3;
    localparam int AV    = NREQ * AW;
    localparam int DV    = NREQ * WIDTH;

    typedef logic [AV-1:0] addr_v_t;
    typedef logic [DV-1:0] data_v_t;

    typedef struct {
        int unsigned       stamp;
        logic [NREQ-1:0]   ack;
        logic              err;
        logic [NREG-1:0]   wr_en;
        logic [WIDTH-1:0]  data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    addr_v_t           req_addr = '0;
    data_v_t           req_data = '0;
    logic              cfg_we = 1'b0;
    logic [NREG-1:0]   cfg_wp = '0;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic [NREG-1:0]   wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic [NREG-1:0]   wp_mask;

    exp_t              q[$];
    int unsigned       cyc   = 0;
    int unsigned       total = 0;
    int unsigned       bad   = 0;

    int                m_ptr = 0;
    logic [NREQ-1:0]   m_ack = '0;
    logic [NREG-1:0]   m_wp  = '0;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .cfg_we(cfg_we), .cfg_wp(cfg_wp), .ack(ack), .err(err), .wr_en(wr_en),
        .wr_data(wr_data), .wp_mask(wp_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: scan requesters in order ptr, ptr+1, ... and take the first live one.
    task automatic predict();
        logic [NREQ-1:0] elig;
        logic [AW-1:0]   a;
        exp_t            e;
        int              g;
        elig = req & ~m_ack;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && ((elig >> idx) & 1) != 0) g = idx;
        end
        if (g >= 0) begin
            a       = AW'(req_addr >> (g * AW));
            e.stamp = cyc + 1;
            e.ack   = NREQ'(1) << g;
            e.err   = (int'(a) >= NREG) || m_wp[a];
            e.wr_en = e.err ? '0 : NREG'(1) << a;
            e.data  = WIDTH'(req_data >> (g * WIDTH));
            q.push_back(e);
            m_ack = e.ack;
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_ack = '0;
        end
        if (cfg_we) m_wp = cfg_wp;
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input addr_v_t a, input data_v_t d,
                         input logic we, input logic [NREG-1:0] wp);
        req = r; req_addr = a; req_data = d; cfg_we = we; cfg_wp = wp;
        predict();
    endtask

    task automatic step(input logic [NREQ-1:0] r, input addr_v_t a, input data_v_t d,
                        input logic we, input logic [NREG-1:0] wp);
        drive(r, a, d, we, wp);
        @(posedge clk); #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, '0);
    endtask

    // Called at posedge+3; anything predicted but not yet clocked is discarded.
    task automatic do_reset();
        rst = 1'b1; req = '0; cfg_we = 1'b0;
        q.delete();
        m_ptr = 0; m_ack = '0; m_wp = '0;
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_wp_mask", 32'(wp_mask), 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (ack != '0) begin
                if (q.size() == 0 || q[0].stamp != cyc) begin
                    check("unexpected_ack", 32'(ack), 0);
                end else begin
                    e = q.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    check("err", 32'(err), 32'(e.err));
                    check("wr_en", 32'(wr_en), 32'(e.wr_en));
                    if (!e.err) check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end else begin
                if (q.size() != 0 && q[0].stamp <= cyc) begin
                    e = q.pop_front();
                    check("missing_ack", 32'(ack), 32'(e.ack));
                end
                check("idle_wr_en", 32'(wr_en), 0);
                check("idle_err", 32'(err), 0);
            end
            check("wp_mask", 32'(wp_mask), 32'(m_wp));
        end
    end

    initial begin : stim
        logic [NREQ-1:0] r;
        addr_v_t         a;
        data_v_t         d;
        @(posedge clk); #3;
        do_reset();

        // Single write: requester 1 to register 3.
        step(4'b0010, addr_v_t'(3) << AW, data_v_t'(8'hA5) << WIDTH, 1'b0, '0);
        idle(2);

        // All requesters held from reset: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++)
            step(4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, data_v_t'($urandom), 1'b0, '0);
        idle(2);

        // Protect register 2, then write it (rejected) and register 5 (accepted).
        step('0, '0, '0, 1'b1, 8'h04);
        step(4'b0100, addr_v_t'(2) << (2 * AW), data_v_t'(8'h3C) << (2 * WIDTH), 1'b0, '0);
        idle(1);
        step(4'b0100, addr_v_t'(5) << (2 * AW), data_v_t'(8'h5A) << (2 * WIDTH), 1'b0, '0);
        idle(2);

        // Mask load and grant on the same edge: old mask applies.
        do_reset();
        step(4'b0100, addr_v_t'(2) << (2 * AW), data_v_t'(8'h11) << (2 * WIDTH), 1'b1, 8'h04);
        idle(1);
        step(4'b0100, addr_v_t'(2) << (2 * AW), data_v_t'(8'h22) << (2 * WIDTH), 1'b0, '0);
        idle(2);

        // Reset in the cycle after a grant edge, and reset with a grant in flight.
        step(4'b0001, addr_v_t'(1), data_v_t'(8'h77), 1'b1, 8'hF0);
        do_reset();
        idle(3);
        drive(4'b0010, addr_v_t'(4) << AW, data_v_t'(8'h99) << WIDTH, 1'b1, 8'hFF);
        do_reset();
        idle(3);
        step(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, data_v_t'($urandom), 1'b0, '0);
        idle(2);

        // Random traffic with requesters that hold until ack and sometimes withdraw.
        r = '0; a = '0; d = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r[i] && m_ack[i]) begin
                    r[i] = ($urandom_range(1, 0) == 1);
                    a[i*AW +: AW] = AW'($urandom);
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if (r[i]) begin
                    if ($urandom_range(15, 0) == 0) r[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    r[i] = 1'b1;
                    a[i*AW +: AW] = AW'($urandom);
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            step(r, a, d, ($urandom_range(9, 0) == 0), NREG'($urandom));
        end
        idle(3);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width of each register in the bank.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of write requesters (2..8).
REQ-003 SHALL have parameter NREG, default 8, meaning number of registers in the bank (2..16); AW = clog2(NREG).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester write request, level, held until ack.
REQ-007 SHALL have port req_addr  input  NREQ x AW  per-requester target register index.
REQ-008 SHALL have port req_data  input  NREQ x WIDTH  per-requester write data.
REQ-009 SHALL have port cfg_we  input  1  load write-protect mask this cycle.
REQ-010 SHALL have port cfg_wp  input  NREG  write-protect mask value; bit i = 1 protects register i.
REQ-011 SHALL have port ack  output  NREQ  one-hot, one-cycle completion pulse to granted requester.
REQ-012 SHALL have port err  output  1  qualifies ack: write rejected (protected or out-of-range address).
REQ-013 SHALL have port wr_en  output  NREG  one-hot (or zero) write enable, one bit per bank register.
REQ-014 SHALL have port wr_data  output  WIDTH  shared write data to all bank registers.
REQ-015 SHALL have port wp_mask  output  NREG  current write-protect mask.

Function
REQ-016 SHALL grant at most one requester per cycle; all of ack, err, wr_en, wr_data registered.
REQ-017 SHALL use round-robin: candidates searched from pointer rr_ptr upward, wrapping NREQ-1 -> 0; lowest qualifying index wins.
REQ-018 SHALL exclude from arbitration any requester whose ack is asserted in the current cycle (no double grant on held req).
REQ-019 SHALL, on grant of requester g at edge N, assert ack[g] for exactly the cycle after edge N (latency 1).
REQ-020 SHALL, for an accepted grant, assert wr_en[req_addr[g]] and drive wr_data = req_data[g] in the same cycle as ack[g], err = 0.
REQ-021 SHALL reject a grant when req_addr[g] >= NREG or wp_mask[req_addr[g]] = 1: ack[g] = 1, err = 1, wr_en = 0.
REQ-022 SHALL set rr_ptr = (g + 1) mod NREQ after each grant, accepted or rejected; rr_ptr unchanged when no grant.
REQ-023 SHALL hold wr_en = 0, ack = 0, err = 0 in cycles with no grant; wr_data holds its last value.
REQ-024 SHALL load wp_mask from cfg_wp on edge with cfg_we = 1; arbitration at that same edge uses the old mask.
REQ-025 SHALL sample req_addr/req_data only at the grant edge; changes after grant do not affect the issued write.
REQ-026 SHALL treat req deasserted before ack as withdrawn; no write, no ack.

Reset
REQ-027 SHALL, while rst = 1, force ack = 0, err = 0, wr_en = 0, wr_data = 0, wp_mask = 0, rr_ptr = 0.
REQ-028 SHALL discard any grant in flight when rst asserts mid-operation; no wr_en or ack after reset release without new req.
REQ-029 SHALL begin arbitration on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place default WIDTH/NREQ/NREG constants and the requester-index and register-index typedefs in shared package cpu_pkg.
REQ-031 SHALL implement the round-robin selection as sub-module rr_arbiter (inputs request vector and pointer, outputs one-hot grant and valid).
REQ-032 SHALL connect wr_en[i]/wr_data to the wr_en/in ports of bank register i without glue logic.

Verification
REQ-033 SHALL cover: single req[1]=1, addr=3, data=0xA5 -> next cycle ack=0b0010, wr_en=0x08, wr_data=0xA5, err=0.
REQ-034 SHALL cover: req=0b1111 held continuously from reset -> grants in order 0,1,2,3,0 on consecutive cycles, one ack per cycle.
REQ-035 SHALL cover: cfg_we=1, cfg_wp=0x04, then req[2]=1 addr=2 -> ack[2]=1, err=1, wr_en=0; addr=5 accepted normally.
REQ-036 SHALL cover: cfg_we and a grant to addr 2 at the same edge with cfg_wp=0x04 -> write accepted (old mask), next write to addr 2 rejected.
REQ-037 SHALL cover: rst pulsed on the cycle after a grant edge -> ack, wr_en remain 0, rr_ptr=0, wp_mask=0 after release.
